// File: rtl/layer_sched_pkg.sv
// Shared definitions for the layer scheduler: controller state encoding,
// data widths and the bit layout of one weight-memory word
// {b, w4, w3, w2, w1}.
package layer_sched_pkg;

   localparam int W_DATA = 8;
   localparam int W_MEM  = 40;

   // Field offsets inside one weight-memory word
   localparam int OFF_W1 = 0;
   localparam int OFF_W2 = 8;
   localparam int OFF_W3 = 16;
   localparam int OFF_W4 = 24;
   localparam int OFF_B  = 32;

   typedef enum logic [2:0] {
      ST_FLUSH = 3'd0,
      ST_IDLE  = 3'd1,
      ST_ISSUE = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // Extract one 8-bit field from a weight-memory word
   function automatic logic [W_DATA-1:0] mem_field(input logic [W_MEM-1:0] word,
                                                   input int unsigned     lsb);
      return word[lsb +: W_DATA];
   endfunction

endpackage

// File: rtl/layer_out_bank.sv
// Result bank for one layer: captures neuron results in arrival order.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : restart collection at byte 0 (bytes themselves are kept)
//   capture    : a result is presented on n_y this cycle
//   n_y        : neuron result
//   y_all      : byte j holds the j-th captured result
//   full       : all N_OUT results have been captured
module layer_out_bank
   import layer_sched_pkg::*;
#(
   parameter int N_OUT = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic                     capture,
   input  logic [W_DATA-1:0]        n_y,
   output logic [W_DATA*N_OUT-1:0]  y_all,
   output logic                     full
);

   localparam int CW = $clog2(N_OUT + 1);

   logic [CW-1:0]             collect_cnt;
   logic [W_DATA*N_OUT-1:0]   bank;
   logic                      take;

   // Once full, further results are dropped: no wrap, no overwrite
   assign full  = (collect_cnt == CW'(N_OUT));
   assign take  = capture && !full;
   assign y_all = bank;

   // Collect counter: cleared on a new run, advances per captured result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         collect_cnt <= '0;
      end else if (clear) begin
         collect_cnt <= '0;
      end else if (take) begin
         collect_cnt <= collect_cnt + 1'b1;
      end
   end

   // Capture registers: result goes into the byte selected by the counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bank <= '0;
      end else begin
         for (int j = 0; j < N_OUT; j++) begin
            if (take && (collect_cnt == CW'(j))) begin
               bank[j*W_DATA +: W_DATA] <= n_y;
            end
         end
      end
   end

endmodule

// File: rtl/layer_sched.sv
// Layer scheduler: time-multiplexes one pipelined neuron across N_OUT
// output neurons. On start it latches x1..x4, reads one weight/bias row per
// cycle from a synchronous weight memory, issues each row to the neuron and
// collects the results in issue order, pulsing done when the layer is full.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : run request, honoured only in IDLE
//   x1..x4              : layer inputs (unsigned), latched on accepted start
//   busy, done          : status (busy outside IDLE, one-cycle done pulse)
//   y_all               : result bank, byte j = neuron j
//   mem_re, mem_addr    : weight-memory read port (address = neuron index)
//   mem_rdata           : {b, w4, w3, w2, w1}, valid the cycle after mem_re
//   n_w1..n_w4, n_b     : weights/bias to the neuron
//   n_x1..n_x4, n_new   : inputs and issue strobe to the neuron
//   n_y, n_ready        : neuron result and its valid flag
module layer_sched
   import layer_sched_pkg::*;
#(
   parameter int N_OUT = 4,
   parameter int AW    = 4,
   parameter int FLUSH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [W_DATA-1:0]        x1,
   input  logic [W_DATA-1:0]        x2,
   input  logic [W_DATA-1:0]        x3,
   input  logic [W_DATA-1:0]        x4,
   output logic                     busy,
   output logic                     done,
   output logic [W_DATA*N_OUT-1:0]  y_all,
   output logic                     mem_re,
   output logic [AW-1:0]            mem_addr,
   input  logic [W_MEM-1:0]         mem_rdata,
   output logic [W_DATA-1:0]        n_w1,
   output logic [W_DATA-1:0]        n_w2,
   output logic [W_DATA-1:0]        n_w3,
   output logic [W_DATA-1:0]        n_w4,
   output logic [W_DATA-1:0]        n_b,
   output logic [W_DATA-1:0]        n_x1,
   output logic [W_DATA-1:0]        n_x2,
   output logic [W_DATA-1:0]        n_x3,
   output logic [W_DATA-1:0]        n_x4,
   output logic                     n_new,
   input  logic [W_DATA-1:0]        n_y,
   input  logic                     n_ready
);

   localparam int FW = $clog2(FLUSH + 1);

   state_t              state;
   state_t              state_nx;
   logic [FW-1:0]       flush_cnt;
   logic [FW-1:0]       flush_cnt_nx;
   logic [AW-1:0]       issue_cnt;
   logic [AW-1:0]       issue_cnt_nx;
   logic                accept;
   logic                capture;
   logic                full;
   logic                rd_valid;
   logic [W_DATA-1:0]   xr1;
   logic [W_DATA-1:0]   xr2;
   logic [W_DATA-1:0]   xr3;
   logic [W_DATA-1:0]   xr4;

   // Next-state, flush/issue counter update and start acceptance
   always_comb begin
      state_nx     = state;
      flush_cnt_nx = flush_cnt;
      issue_cnt_nx = issue_cnt;
      accept       = 1'b0;
      case (state)
         ST_FLUSH: begin
            if (flush_cnt == FW'(FLUSH - 1)) begin
               state_nx = ST_IDLE;
            end else begin
               flush_cnt_nx = flush_cnt + 1'b1;
            end
         end
         ST_IDLE: begin
            if (start) begin
               accept       = 1'b1;
               issue_cnt_nx = '0;
               state_nx     = ST_ISSUE;
            end else begin
               state_nx = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            // Hold the address at the last row rather than wrapping
            if (issue_cnt == AW'(N_OUT - 1)) begin
               state_nx = ST_DRAIN;
            end else begin
               issue_cnt_nx = issue_cnt + 1'b1;
            end
         end
         ST_DRAIN: begin
            if (full) begin
               state_nx = ST_DONE;
            end else begin
               state_nx = ST_DRAIN;
            end
         end
         ST_DONE: begin
            state_nx = ST_IDLE;
         end
         default: begin
            state_nx = ST_FLUSH;
         end
      endcase
   end

   // State, counters and registered status/read-port outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_FLUSH;
         flush_cnt <= '0;
         issue_cnt <= '0;
         busy      <= 1'b1;
         done      <= 1'b0;
         mem_re    <= 1'b0;
         rd_valid  <= 1'b0;
      end else begin
         state     <= state_nx;
         flush_cnt <= flush_cnt_nx;
         issue_cnt <= issue_cnt_nx;
         busy      <= (state_nx != ST_IDLE);
         done      <= (state_nx == ST_DONE);
         mem_re    <= (state_nx == ST_ISSUE);
         // Read data appears one cycle after mem_re; issue it then
         rd_valid  <= mem_re;
      end
   end

   // Layer input latch, loaded only when a run is accepted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xr1 <= '0;
         xr2 <= '0;
         xr3 <= '0;
         xr4 <= '0;
      end else if (accept) begin
         xr1 <= x1;
         xr2 <= x2;
         xr3 <= x3;
         xr4 <= x4;
      end
   end

   assign mem_addr = issue_cnt;
   assign n_new    = rd_valid;
   assign n_x1     = xr1;
   assign n_x2     = xr2;
   assign n_x3     = xr3;
   assign n_x4     = xr4;
   assign n_w1     = mem_field(mem_rdata, OFF_W1);
   assign n_w2     = mem_field(mem_rdata, OFF_W2);
   assign n_w3     = mem_field(mem_rdata, OFF_W3);
   assign n_w4     = mem_field(mem_rdata, OFF_W4);
   assign n_b      = mem_field(mem_rdata, OFF_B);

   // Results only count while a run is in flight; FLUSH/IDLE/DONE drop them
   assign capture = n_ready && ((state == ST_ISSUE) || (state == ST_DRAIN));

   layer_out_bank #(
      .N_OUT (N_OUT)
   ) u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (accept),
      .capture (capture),
      .n_y     (n_y),
      .y_all   (y_all),
      .full    (full)
   );

endmodule

// File: doc/layer_sched.md
Name: layer_sched

Overview:
- Time-multiplexes one shared pipelined `neuron` instance across N_OUT output neurons of a single layer.
- On `start`, latches the 4-element layer input vector and streams one weight/bias set per cycle from an external synchronous weight memory into the neuron.
- Collects each neuron result, in issue order, into an output bank and pulses `done` when the layer is complete.
- Sits between the layer input registers and the next layer (or the decoder output stage).

Parameters:
- N_OUT, 4: number of output neurons sequenced per layer; legal range 1..16.
- AW, 4: weight-memory address width; N_OUT <= 2**AW.
- FLUSH, 16: cycles held in FLUSH after reset release; must exceed the neuron's `new`-to-`ready` latency.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request a layer evaluation; sampled only in IDLE.
- x1, x2, x3, x4  in  8 each  layer inputs, unsigned; latched on accepted start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when all N_OUT results are captured.
- y_all  out  8*N_OUT  result bank; byte j = output of neuron j, unsigned.
- mem_re  out  1  weight-memory read enable.
- mem_addr  out  AW  weight-memory address (= neuron index).
- mem_rdata  in  40  {b, w4, w3, w2, w1}, each 8-bit signed; valid the cycle after mem_re.
- n_w1, n_w2, n_w3, n_w4, n_b  out  8 each  to the neuron; driven from mem_rdata fields.
- n_x1, n_x2, n_x3, n_x4  out  8 each  to the neuron; latched x values.
- n_new  out  1  to the neuron; issue strobe.
- n_y  in  8  from the neuron: result.
- n_ready  in  1  from the neuron: result valid.

Behaviour:
- Reset values (rst_n=0, asynchronous):
  - state=FLUSH, busy=1, done=0, y_all=0, mem_re=0, mem_addr=0.
  - n_new=0; latched x=0, so n_x*=0.
  - issue counter and collect counter = 0.
- States: FLUSH, IDLE, ISSUE, DRAIN, DONE.
- FLUSH:
  - Counts FLUSH cycles with n_new=0 and n_ready ignored, then goes to IDLE.
  - Purpose: the neuron has no reset, so results still in flight are discarded.
- IDLE:
  - busy=0; start=1 latches x1..x4, clears both counters, goes to ISSUE.
  - n_ready is ignored.
- ISSUE, one read per cycle:
  - mem_re=1, mem_addr=issue_cnt; issue_cnt increments.
  - After the cycle with mem_addr=N_OUT-1, mem_re=0 and state goes to DRAIN.
- Issue alignment:
  - rd_valid is mem_re delayed one cycle; n_new = rd_valid.
  - n_w*/n_b come from mem_rdata in that same cycle.
  - Exactly N_OUT n_new pulses per run, on consecutive cycles, starting 2 cycles after start is accepted.
- Collection, active in ISSUE and DRAIN:
  - On each n_ready=1, y_all byte collect_cnt <= n_y and collect_cnt increments.
  - Results arrive in issue order; the neuron pipeline preserves order.
  - n_ready after collect_cnt reaches N_OUT is ignored; no wrap and no overwrite.
- DRAIN: when collect_cnt==N_OUT, go to DONE. This also covers the case where the final capture and the ISSUE→DRAIN transition fall in the same cycle.
- DONE: done=1 for exactly one cycle, then IDLE. start is ignored in DONE.
- Held start: a start held high across DONE begins a new run on the first IDLE cycle.
- y_all stability: held stable from DONE until the first capture of the next run. Bytes are not cleared on start.
- start while busy: ignored; no queuing.
- Mid-operation reset: asserting rst_n mid-run aborts immediately to reset values. The FLUSH state guarantees no stale n_ready is counted in the next run.
- N_OUT=1: single issue; ISSUE lasts 1 cycle.
- Arithmetic: the controller performs none. Widths pass through unchanged; signedness is interpreted by the neuron.

Decomposition:
- Shared package holds:
  - state encoding constants: FLUSH, IDLE, ISSUE, DRAIN, DONE;
  - W_DATA=8, W_MEM=40;
  - mem_rdata field offsets: W1 [7:0], W2 [15:8], W3 [23:16], W4 [31:24], B [39:32].
- One natural sub-module: `layer_out_bank`, holding the N_OUT×8 capture registers, the collect counter and the full flag.
- FSM and issue logic stay in `layer_sched`.

Test Plan:
- Reset release: busy=1 for exactly 16 cycles, then busy=0. All outputs 0 throughout. n_ready pulses injected during FLUSH leave y_all=0.
- Basic run, N_OUT=4, real neuron plus 1-cycle memory model:
  - x=(4,8,12,16); row j has w=1,1,1,1 and b=4j, so sum=40+4j.
  - Expected y_all bytes = 10, 11, 12, 13.
  - mem_addr sequence 0,1,2,3 on consecutive cycles; n_new high 4 consecutive cycles; done is a single pulse.
- Negative row: row 2 has w=-1,-1,-1,-1, b=0, so sum=-40. Expected byte 2 = 0; other bytes as above.
- start handling:
  - start pulsed during ISSUE and DRAIN → no extra mem_re and no second done.
  - start held high → second run begins on the IDLE cycle after done.
- Reset during run: rst_n asserted at the 3rd ISSUE cycle → y_all=0 and busy=1 immediately. After FLUSH, a run with x=(4,8,12,16) reproduces bytes 10..13 exactly.
- Boundary N_OUT=1, x=(255,0,0,0), w1=1, b=0 → y_all=63 (255>>2). Exactly one n_new and one done.
